// File: rtl/mips_pkg.sv
// Shared register-file definitions for the MIPS datapath: address/data widths,
// the hard-wired zero register and a one-hot register decoder.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // One-hot decode of a register address, used for the pending-write mask.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr (wrapping). The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] winner_c,
  output logic             any_c
);

  int unsigned idx;

  always_comb begin
    grant_c  = '0;
    winner_c = '0;
    any_c    = 1'b0;
    idx      = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!any_c && req[IDX_W'(idx)]) begin
        any_c                  = 1'b1;
        grant_c[IDX_W'(idx)]   = 1'b1;
        winner_c               = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ
// write-back sources, with a registered write stage and a pending-write mask.
module reg_file_wr_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned DATA_W = REG_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [NUM_REGS-1:0]        pending_mask,
  output logic [$clog2(N_REQ)-1:0]   grant_idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic [N_REQ-1:0] grant_c;
  logic [IDX_W-1:0] winner_c;
  logic             any_c;

  logic [IDX_W-1:0]    rr_ptr_q,       rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx_q,    grant_idx_d;
  logic                wr_en_q,        wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q,      wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q,      wr_data_d;
  logic [NUM_REGS-1:0] pending_mask_q, pending_mask_d;

  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              issue;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant_c  (grant_c),
    .winner_c (winner_c),
    .any_c    (any_c)
  );

  // Grants are withheld while reset is asserted so no requester sees a transfer.
  assign req_ready = rst_n ? grant_c : '0;

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    grant_idx_d    = grant_idx_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    pending_mask_d = '0;

    win_addr = addr_arr[winner_c];
    win_data = data_arr[winner_c];
    // r0 writes are consumed (handshake completes) but never reach the file.
    issue    = any_c && (win_addr != ADDR_W'(ZERO_REG));

    if (any_c) begin
      rr_ptr_d    = (winner_c == IDX_W'(N_REQ - 1)) ? '0 : winner_c + IDX_W'(1);
      grant_idx_d = winner_c;
    end

    if (issue) begin
      wr_en_d        = 1'b1;
      wr_addr_d      = win_addr;
      wr_data_d      = win_data;
      pending_mask_d = reg_onehot(reg_addr_t'(win_addr));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      pending_mask_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      grant_idx_q    <= grant_idx_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      pending_mask_q <= pending_mask_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign pending_mask = pending_mask_q;
  assign grant_idx    = grant_idx_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Directed testbench for reg_file_wr_arbiter with a small register-file model
// fed from the write port.
module tb_reg_file_wr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [31:0]       pending_mask;
  logic [1:0]        grant_idx;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  reg_file_wr_arbiter #(
    .N_REQ  (N),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending_mask (pending_mask),
    .grant_idx    (grant_idx)
  );

  always #5 clk = ~clk;

  // Register file model committing whatever the write port presents.
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 5'd1, 32'h1);
    set_req(1, 5'd2, 32'h2);
    set_req(2, 5'd3, 32'h3);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected %b", req_ready, 3'b000);
    end
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx} !== {1'b0, 5'd0, 32'h0, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h mask=%h gidx=%0d expected all zero",
               wr_en, wr_addr, wr_data, pending_mask, grant_idx);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({wr_en, pending_mask, req_ready} !== {1'b0, 32'h0, 3'b000}) begin
        errors++;
        $display("FAIL idle_%0d: got en=%b mask=%h ready=%b expected en=0 mask=0 ready=000",
                 k, wr_en, pending_mask, req_ready);
      end
    end
  endtask

  task automatic test_single();
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL single_ready: got %b expected %b", req_ready, 3'b010);
    end
    step();
    req_valid = '0;
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx} !==
        {1'b1, 5'd5, 32'hDEADBEEF, 32'h20, 2'd1}) begin
      errors++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h mask=%h gidx=%0d expected 1/5/deadbeef/20/1",
               wr_en, wr_addr, wr_data, pending_mask, grant_idx);
    end
    step();
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask} !== {1'b0, 5'd5, 32'hDEADBEEF, 32'h0}) begin
      errors++;
      $display("FAIL single_hold: got en=%b addr=%0d data=%h mask=%h expected 0/5/deadbeef/0",
               wr_en, wr_addr, wr_data, pending_mask);
    end
  endtask

  task automatic test_round_robin();
    int last [N];
    int max_wait;
    int w;
    logic [2:0] exp_rdy;
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 5'(10 + i), 32'hC0DE0000 + 32'(i));
      last[i] = -1;
    end
    max_wait = 0;
    for (int k = 0; k < 6; k++) begin
      int e;
      e = k % 3;
      exp_rdy = 3'b001 << e;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready_%0d: got %b expected %b", k, req_ready, exp_rdy);
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          w = k - last[i];
          if (w > max_wait) max_wait = w;
          last[i] = k;
        end
      end
      step();
      checks++;
      if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx} !==
          {1'b1, 5'(10 + e), 32'hC0DE0000 + 32'(e), 32'(1) << (10 + e), 2'(e)}) begin
        errors++;
        $display("FAIL rr_write_%0d: got en=%b addr=%0d data=%h mask=%h gidx=%0d expected requester %0d",
                 k, wr_en, wr_addr, wr_data, pending_mask, grant_idx, e);
      end
    end
    checks++;
    if (max_wait > 3) begin
      errors++;
      $display("FAIL rr_starvation: got max wait %0d expected <= 3", max_wait);
    end
    req_valid = '0;
  endtask

  task automatic test_r0_write();
    set_req(0, 5'd0, 32'h1234);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL r0_ready: got %b expected %b", req_ready, 3'b001);
    end
    step();
    checks++;
    if ({wr_en, pending_mask, grant_idx, wr_addr, wr_data} !==
        {1'b0, 32'h0, 2'd0, 5'd12, 32'hC0DE0002}) begin
      errors++;
      $display("FAIL r0_suppressed: got en=%b mask=%h gidx=%0d addr=%0d data=%h expected 0/0/0/12/c0de0002",
               wr_en, pending_mask, grant_idx, wr_addr, wr_data);
    end
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd4, 32'h44);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL r0_ptr_advance: got %b expected %b", req_ready, 3'b010);
    end
    step();
    req_valid[1] = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx} !== {1'b1, 5'd4, 32'h44, 32'h10, 2'd1}) begin
      errors++;
      $display("FAIL r0_next_write: got en=%b addr=%0d data=%h mask=%h gidx=%0d expected 1/4/44/10/1",
               wr_en, wr_addr, wr_data, pending_mask, grant_idx);
    end
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL r0_wrap: got %b expected %b", req_ready, 3'b001);
    end
    step();
    req_valid = '0;
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx} !== {1'b1, 5'd3, 32'h33, 32'h8, 2'd0}) begin
      errors++;
      $display("FAIL r0_wrap_write: got en=%b addr=%0d data=%h mask=%h gidx=%0d expected 1/3/33/8/0",
               wr_en, wr_addr, wr_data, pending_mask, grant_idx);
    end
  endtask

  task automatic test_collision();
    do_reset();
    rf[7] = 32'h0;
    set_req(0, 5'd7, 32'hA);
    set_req(2, 5'd7, 32'hB);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL coll_ready0: got %b expected %b", req_ready, 3'b001);
    end
    step();
    req_valid[0] = 1'b0;
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask} !== {1'b1, 5'd7, 32'hA, 32'h80}) begin
      errors++;
      $display("FAIL coll_first: got en=%b addr=%0d data=%h mask=%h expected 1/7/a/80",
               wr_en, wr_addr, wr_data, pending_mask);
    end
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL coll_ready2: got %b expected %b", req_ready, 3'b100);
    end
    step();
    req_valid = '0;
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx, rf[7]} !==
        {1'b1, 5'd7, 32'hB, 32'h80, 2'd2, 32'hA}) begin
      errors++;
      $display("FAIL coll_second: got en=%b addr=%0d data=%h mask=%h gidx=%0d r7=%h expected 1/7/b/80/2/a",
               wr_en, wr_addr, wr_data, pending_mask, grant_idx, rf[7]);
    end
    step();
    checks++;
    if ({wr_en, rf[7]} !== {1'b0, 32'hB}) begin
      errors++;
      $display("FAIL coll_final: got en=%b r7=%h expected en=0 r7=b", wr_en, rf[7]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf[9] = 32'h0;
    set_req(1, 5'd9, 32'h99);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL midrst_ready: got %b expected %b", req_ready, 3'b010);
    end
    step();
    req_valid = '0;
    checks++;
    if ({wr_en, wr_addr, pending_mask} !== {1'b1, 5'd9, 32'h200}) begin
      errors++;
      $display("FAIL midrst_inflight: got en=%b addr=%0d mask=%h expected 1/9/200",
               wr_en, wr_addr, pending_mask);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, pending_mask, wr_addr, wr_data, grant_idx} !== {1'b0, 32'h0, 5'd0, 32'h0, 2'd0}) begin
      errors++;
      $display("FAIL midrst_async: got en=%b mask=%h addr=%0d data=%h gidx=%0d expected all zero",
               wr_en, pending_mask, wr_addr, wr_data, grant_idx);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rf[9] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_discard: got r9=%h expected 0", rf[9]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_req(0, 5'd1, 32'h11);
    set_req(1, 5'd2, 32'h22);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL midrst_ptr: got %b expected %b", req_ready, 3'b001);
    end
    step();
    req_valid = '0;
    checks++;
    if ({wr_en, wr_addr, wr_data, pending_mask, grant_idx} !== {1'b1, 5'd1, 32'h11, 32'h2, 2'd0}) begin
      errors++;
      $display("FAIL midrst_first: got en=%b addr=%0d data=%h mask=%h gidx=%0d expected 1/1/11/2/0",
               wr_en, wr_addr, wr_data, pending_mask, grant_idx);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_r0_write();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
